// File: rtl/board_io_wrapper_if.sv
// Board-side bus: raw button pins and LED pins toward the wrapper, clean
// button levels/pulses and LED controls between the wrapper and main logic.
interface board_io_wrapper_if #(
  parameter int unsigned NUM_BUTTONS = 2,
  parameter int unsigned NUM_LEDS    = 3,
  parameter int unsigned PWM_WIDTH   = 8
);
  logic [NUM_BUTTONS-1:0]        push_button_n;
  logic [NUM_BUTTONS-1:0]        push_button;
  logic [NUM_BUTTONS-1:0]        push_button_press;
  logic [NUM_BUTTONS-1:0]        push_button_release;
  logic [NUM_LEDS-1:0]           led;
  logic [NUM_LEDS*PWM_WIDTH-1:0] led_duty;
  logic [NUM_LEDS-1:0]           led_n;

  // Drives the wrapper: board pins plus main-logic LED controls.
  modport master (
    output push_button_n,
    output led,
    output led_duty,
    input  push_button,
    input  push_button_press,
    input  push_button_release,
    input  led_n
  );

  // The wrapper itself.
  modport slave (
    input  push_button_n,
    input  led,
    input  led_duty,
    output push_button,
    output push_button_press,
    output push_button_release,
    output led_n
  );
endinterface

// File: rtl/board_io_wrapper.sv
// Board I/O wrapper: synchronises and debounces active-low push buttons into
// clean levels with press/release pulses, and drives active-low LEDs with
// per-channel PWM whose duty is shadowed at period boundaries.
module board_io_wrapper #(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned NUM_LEDS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEBOUNCE_WIDTH  = 16,
  parameter int unsigned PWM_WIDTH       = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  board_io_wrapper_if.slave   bus
);

  localparam logic [DEBOUNCE_WIDTH-1:0] DbLast = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button synchroniser: flops hold the raw active-low level, so reset is 1.
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] btn_sync;
  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] stable_dly_q;

  // Two-stage synchroniser, straight flop-to-flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.push_button_n;
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Per-button debounce: a new level must hold DEBOUNCE_CYCLES samples in a row.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      stable_q, stable_d;

    // Any sample that agrees with the stable level discards accumulated credit.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (btn_sync[b] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == DbLast) begin
        stable_d = btn_sync[b];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
      end
    end

    // Debounce state registers.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable[b] = stable_q;
  end

  // Delayed copy of the stable levels for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
    end else begin
      stable_dly_q <= stable;
    end
  end

  assign bus.push_button         = stable;
  assign bus.push_button_press   = stable & ~stable_dly_q;
  assign bus.push_button_release = ~stable & stable_dly_q;

  // ---------------------------------------------------------------------------
  // PWM: free-running counter, duties shadowed on the last count of a period.
  // ---------------------------------------------------------------------------
  logic [PWM_WIDTH-1:0]          pwm_q;
  logic [NUM_LEDS*PWM_WIDTH-1:0] duty_q;
  logic [NUM_LEDS-1:0]           led_on;
  logic [NUM_LEDS-1:0]           led_n_q;
  logic                          period_end;

  assign period_end = (pwm_q == {PWM_WIDTH{1'b1}});

  // Counter wraps naturally; shadow duties load so they apply from count 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_WIDTH'(1);
      if (period_end) begin
        duty_q <= bus.led_duty;
      end
    end
  end

  // All-ones duty means always on; otherwise on while the count is below duty.
  always_comb begin
    led_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_on[i] = bus.led[i] &
                  ((duty_q[i*PWM_WIDTH +: PWM_WIDTH] == {PWM_WIDTH{1'b1}}) |
                   (pwm_q < duty_q[i*PWM_WIDTH +: PWM_WIDTH]));
    end
  end

  // Registered active-low LED pins; reset leaves every LED dark.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_n_q <= '1;
    end else begin
      led_n_q <= ~led_on;
    end
  end

  assign bus.led_n = led_n_q;

endmodule

// File: tb/tb_board_io_wrapper.sv
// Directed bench for board_io_wrapper with short debounce and PWM periods.
module tb_board_io_wrapper;

  localparam int unsigned NB = 2;
  localparam int unsigned NL = 3;
  localparam int unsigned DC = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned PW = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  board_io_wrapper_if #(
    .NUM_BUTTONS (NB),
    .NUM_LEDS    (NL),
    .PWM_WIDTH   (PW)
  ) bus ();

  board_io_wrapper #(
    .NUM_BUTTONS     (NB),
    .NUM_LEDS        (NL),
    .DEBOUNCE_CYCLES (DC),
    .DEBOUNCE_WIDTH  (DW),
    .PWM_WIDTH       (PW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int npress = 0;
  logic [1:0] any_p, any_r;
  logic [15:0] v0, v1, v2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sample/drive 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Same as tick, also counting press pulses on button 0.
  task automatic tickp(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (bus.push_button_press[0]) npress++;
    end
  endtask

  // One PWM period of samples; bit i set when LED lit after the i-th edge.
  task automatic sample_period(input int change_at, input logic [NL*PW-1:0] new_duty);
    for (int i = 0; i < 16; i++) begin
      if (i == change_at) bus.led_duty = new_duty;
      tick(1);
      v0[i] = ~bus.led_n[0];
      v1[i] = ~bus.led_n[1];
      v2[i] = ~bus.led_n[2];
    end
  endtask

  initial begin
    bus.push_button_n = 2'b11;
    bus.led           = '0;
    bus.led_duty      = '0;

    // Reset state
    tick(2);
    check("rst_pb",      bus.push_button, 2'b00);
    check("rst_press",   bus.push_button_press, 2'b00);
    check("rst_release", bus.push_button_release, 2'b00);
    check("rst_led_n",   bus.led_n, 3'b111);
    reset_n = 1'b1;

    // Button 0 press: accepted at edge 6 after the first sampling edge
    bus.push_button_n = 2'b10;
    tick(5);
    check("press_early_pb", bus.push_button, 2'b00);
    tick(1);
    check("press_pb",       bus.push_button, 2'b01);
    check("press_pulse",    bus.push_button_press, 2'b01);
    check("press_no_rel",   bus.push_button_release, 2'b00);
    tick(1);
    check("press_pulse_end", bus.push_button_press, 2'b00);
    check("press_pb_hold",   bus.push_button, 2'b01);

    // Button 0 release
    bus.push_button_n = 2'b11;
    tick(5);
    check("rel_early_pb", bus.push_button, 2'b01);
    tick(1);
    check("rel_pulse",    bus.push_button_release, 2'b01);
    check("rel_pb",       bus.push_button, 2'b00);
    tick(1);
    check("rel_pulse_end", bus.push_button_release, 2'b00);

    // Bounce: low 3 samples, high 1, then low and held
    npress = 0;
    bus.push_button_n = 2'b10;
    tickp(3);
    bus.push_button_n = 2'b11;
    tickp(1);
    bus.push_button_n = 2'b10;
    tickp(5);
    check("bounce_hold_pb", bus.push_button, 2'b00);
    tickp(1);
    check("bounce_pb", bus.push_button, 2'b01);
    tickp(2);
    check("bounce_one_press", npress, 1);

    // Both held, then released in the same cycle
    bus.push_button_n = 2'b00;
    tick(8);
    check("both_pb", bus.push_button, 2'b11);
    bus.push_button_n = 2'b11;
    tick(5);
    check("both_rel_early", bus.push_button_release, 2'b00);
    tick(1);
    check("both_rel_pulse", bus.push_button_release, 2'b11);
    check("both_no_press",  bus.push_button_press, 2'b00);
    check("both_rel_pb",    bus.push_button, 2'b00);
    tick(1);
    check("both_rel_end", bus.push_button_release, 2'b00);

    // PWM from a fresh reset so the counter phase is known
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    bus.led      = 3'b111;
    bus.led_duty = {4'd15, 4'd5, 4'd0};
    tick(16);
    sample_period(-1, '0);
    check("pwm_d0",  v0, 16'h0000);
    check("pwm_d5",  v1, 16'h001F);
    check("pwm_d15", v2, 16'hFFFF);

    // Duty change at count 3 leaves the current period untouched
    sample_period(3, {4'd15, 4'd10, 4'd0});
    check("shadow_cur", v1, 16'h001F);
    sample_period(-1, '0);
    check("shadow_next", v1, 16'h03FF);
    check("shadow_ch2",  v2, 16'hFFFF);

    // led enable is not shadowed
    bus.led = 3'b011;
    tick(1);
    check("led_off_mid", bus.led_n[2], 1'b1);
    bus.led = 3'b111;
    tick(1);
    check("led_on_mid", bus.led_n[2], 1'b0);

    // Reset mid-debounce and mid-PWM
    bus.push_button_n = 2'b01;
    tick(8);
    check("pre_rst_pb", bus.push_button, 2'b10);
    bus.push_button_n = 2'b00;
    tick(3);
    check("pre_rst_led", bus.led_n[2], 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_led_n",   bus.led_n, 3'b111);
    check("mid_rst_pb",      bus.push_button, 2'b00);
    check("mid_rst_press",   bus.push_button_press, 2'b00);
    check("mid_rst_release", bus.push_button_release, 2'b00);
    tick(2);
    reset_n = 1'b1;
    any_p = '0;
    any_r = '0;
    repeat (5) begin
      tick(1);
      any_p |= bus.push_button_press;
      any_r |= bus.push_button_release;
    end
    check("post_rst_pb_early", bus.push_button, 2'b00);
    check("post_rst_no_press", any_p, 2'b00);
    check("post_rst_no_rel",   any_r, 2'b00);
    tick(1);
    check("post_rst_pb",    bus.push_button, 2'b11);
    check("post_rst_press", bus.push_button_press, 2'b11);
    tick(1);
    check("post_rst_press_end", bus.push_button_press, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_io_wrapper.md
Name: board_io_wrapper

Overview:
Parametrised successor to the fixed two-button / three-LED board wrapper. Synchronises and debounces NUM_BUTTONS active-low push buttons and emits clean levels plus one-cycle press/release pulses. Drives NUM_LEDS active-low LEDs with per-channel PWM brightness, with duty changes applied glitch-free. Sits between the board pins and the sample main logic in every sample top level.

Parameters:
NUM_BUTTONS, 2, number of push-button inputs
NUM_LEDS, 3, number of LED outputs
DEBOUNCE_CYCLES, 50000, cycles a synchronised input must hold a new level before acceptance; must be at least 1
DEBOUNCE_WIDTH, 16, debounce counter width; 2^DEBOUNCE_WIDTH must be at least DEBOUNCE_CYCLES
PWM_WIDTH, 8, PWM counter and duty width

Ports:
clock  input  1  system clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
push_button_n  input  NUM_BUTTONS  raw board buttons, active-low, asynchronous to clock
push_button  output  NUM_BUTTONS  debounced level, active-high
push_button_press  output  NUM_BUTTONS  one-cycle pulse on debounced 0->1
push_button_release  output  NUM_BUTTONS  one-cycle pulse on debounced 1->0
led  input  NUM_LEDS  LED enable, active-high
led_duty  input  NUM_LEDS*PWM_WIDTH  per-channel duty; channel i occupies bits [i*PWM_WIDTH +: PWM_WIDTH]
led_n  output  NUM_LEDS  board LEDs, active-low, registered

Behaviour:
- Reset (asynchronous assert, synchronous release via clock): push_button, push_button_press and push_button_release are 0. led_n is all 1 (LEDs off). Sync flops hold 1 (inactive raw level). Debounce counters, PWM counter and shadow duties are 0.
- Synchroniser: per button, two flops on ~push_button_n. No logic between the two stages.
- Debounce, per button, with stable register S, synchronised value Y and counter C:
  - Y == S: C <= 0.
  - Y != S and C == DEBOUNCE_CYCLES-1: S <= Y, C <= 0.
  - Y != S otherwise: C <= C+1.
  - A bounce back to S before acceptance clears C; there is no partial credit.
- Latency: if the raw pin changes and holds, and the first rising edge that samples the new level is edge 1, then S changes at edge DEBOUNCE_CYCLES+2.
- Pulses: push_button_press = S & ~S_d and push_button_release = ~S & S_d, where S_d is S delayed one cycle. Each pulse is high for exactly one cycle, in the cycle following the S change. Press and release are never both high.
- Buttons are fully independent; simultaneous changes on several buttons produce simultaneous pulses.
- PWM counter P (PWM_WIDTH bits) free-runs from 0 and wraps from all-ones to 0. The period is 2^PWM_WIDTH cycles.
- Shadow duty D[i]: loaded from led_duty[i] on every edge where P == all-ones, so the new value takes effect from P == 0. A mid-period duty change never alters the current period.
- Channel on-condition: led[i] & ((D[i] == all-ones) | (P < D[i])).
  - D == 0: off for the whole period.
  - D == all-ones: on for all 2^PWM_WIDTH cycles.
  - Otherwise: on for D cycles per period, starting at P == 0.
- led_n[i] <= ~on[i], registered, so there is one cycle of latency from P to the pin.
- led is not shadowed. Deasserting it turns the LED off at the next edge, mid-period.
- Reset mid-operation: all state returns to reset values immediately. Pending debounce counts are discarded, and no pulse is generated by reset assertion or release.

Test Plan:
(Sim parameters: DEBOUNCE_CYCLES=4, PWM_WIDTH=4, NUM_BUTTONS=2, NUM_LEDS=3.)
- Button press: push_button_n[0] 1->0 and held -> push_button[0] rises at edge 6 after the first sampling edge; push_button_press[0] is high for exactly one cycle; button 1 outputs stay 0.
- Bounce rejection: push_button_n[0] low for 3 cycles, high for 1, then low and held -> no change until 6 edges after the final low sample; exactly one press pulse.
- Release and simultaneous edges: both buttons released in the same cycle after a held press -> push_button_release[1:0] = 2'b11 in the same single cycle; push_button_press stays 0.
- PWM duty points: led=3'b111, duties {0, 5, 15} -> over 16 cycles, led_n[0] low for 0 cycles, led_n[1] low for 5 contiguous cycles, led_n[2] low for 16 cycles.
- Shadow update: change channel 1 duty 5->10 while P=3 -> the current period still shows 5 low cycles; the next period shows 10.
- Mid-operation reset: assert reset_n=0 mid-debounce and mid-PWM -> led_n=3'b111 and push_button/pulses 0 immediately. After release, a held-low button needs the full 6 edges again; no spurious pulse.
